// File: rtl/wr_resp_tracker_pkg.sv
// wr_resp_tracker_pkg: shared AXI bridge constants, response codes and request-source encoding
package wr_resp_tracker_pkg;
  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;
  typedef enum logic {
    SRC_INST = 1'b0,
    SRC_DATA = 1'b1
  } req_src_e;
  localparam logic [3:0] BRIDGE_WR_ID = 4'd1;
  function automatic logic resp_err(input logic [1:0] resp, input logic id_ok);
    return (resp != RESP_OKAY) || !id_ok;
  endfunction
endpackage

// File: rtl/wr_pending_fifo.sv
// wr_pending_fifo: pointer/count queue of pending write word addresses exposing valid+addr for hazard compare
module wr_pending_fifo #(
  parameter int DEPTH = 4,
  parameter int AW = 30
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push,
  input  logic [AW-1:0]              push_addr,
  input  logic                       pop,
  output logic [$clog2(DEPTH):0]     count,
  output logic [DEPTH-1:0]           valid,
  output logic [DEPTH-1:0][AW-1:0]   addr,
  output logic                       full,
  output logic                       empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      if (do_push) begin
        valid[wr_ptr] <= 1'b1;
        addr[wr_ptr] <= push_addr;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/wr_resp_tracker.sv
// wr_resp_tracker: in-order AXI B-channel tracker for issued writes with data_ok pulse and RAW hazard flag
module wr_resp_tracker
  import wr_resp_tracker_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ADDR_W = 32,
  parameter int ID_W = 4,
  parameter logic [ID_W-1:0] WR_ID = ID_W'(BRIDGE_WR_ID)
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   push_valid,
  input  logic [ADDR_W-1:0]      push_addr,
  output logic                   push_ready,
  input  logic [ID_W-1:0]        bid,
  input  logic [1:0]             bresp,
  input  logic                   bvalid,
  output logic                   bready,
  output logic                   data_ok,
  output logic                   data_err,
  input  logic [ADDR_W-1:0]      rd_chk_addr,
  output logic                   raw_hazard,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = ADDR_W - 2;
  logic full, b_fire, hz;
  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0][AW-1:0] addr;
  logic unused_lsb;
  assign unused_lsb = ^{push_addr[1:0], rd_chk_addr[1:0]};
  assign push_ready = !full;
  assign bready = !empty;
  assign b_fire = bvalid && bready;
  wr_pending_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push_valid),
    .push_addr (push_addr[ADDR_W-1:2]),
    .pop       (b_fire),
    .count     (count),
    .valid     (valid),
    .addr      (addr),
    .full      (full),
    .empty     (empty)
  );
  always_comb begin
    hz = push_valid && (push_addr[ADDR_W-1:2] == rd_chk_addr[ADDR_W-1:2]);
    for (int i = 0; i < DEPTH; i++)
      hz = hz || (valid[i] && (addr[i] == rd_chk_addr[ADDR_W-1:2]));
  end
  assign raw_hazard = hz;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      data_ok <= 1'b0;
      data_err <= 1'b0;
    end else begin
      data_ok <= b_fire;
      data_err <= b_fire && resp_err(bresp, bid == WR_ID);
    end
  end
endmodule

// File: tb/tb_wr_resp_tracker.sv
// tb_wr_resp_tracker: scoreboard bench for wr_resp_tracker
module tb_wr_resp_tracker;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic resetn;
  logic push_valid;
  logic [31:0] push_addr;
  logic push_ready;
  logic [3:0] bid;
  logic [1:0] bresp;
  logic bvalid;
  logic bready;
  logic data_ok;
  logic data_err;
  logic [31:0] rd_chk_addr;
  logic raw_hazard;
  logic empty;
  logic [2:0] count;
  int n_vec = 0;
  int n_bad = 0;
  logic [29:0] mq[$];
  logic exp_q[$];

  always #5 clk = ~clk;

  wr_resp_tracker #(.DEPTH(DEPTH), .ADDR_W(32), .ID_W(4), .WR_ID(4'd1)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .push_valid  (push_valid),
    .push_addr   (push_addr),
    .push_ready  (push_ready),
    .bid         (bid),
    .bresp       (bresp),
    .bvalid      (bvalid),
    .bready      (bready),
    .data_ok     (data_ok),
    .data_err    (data_err),
    .rd_chk_addr (rd_chk_addr),
    .raw_hazard  (raw_hazard),
    .empty       (empty),
    .count       (count)
  );

  task automatic idle();
    push_valid = 1'b0;
    push_addr = '0;
    bvalid = 1'b0;
    bresp = 2'b00;
    bid = 4'd1;
  endtask

  task automatic tick();
    logic hz, e;
    bit hs, pf;
    #1;
    hz = push_valid && (push_addr[31:2] == rd_chk_addr[31:2]);
    foreach (mq[i]) if (mq[i] == rd_chk_addr[31:2]) hz = 1'b1;
    n_vec++;
    if (raw_hazard !== hz) begin
      n_bad++;
      $display("FAIL sb_hazard got %b want %b t=%0t", raw_hazard, hz, $time);
    end
    pf = resetn && push_valid && (mq.size() != DEPTH);
    hs = resetn && bvalid && (mq.size() != 0);
    @(posedge clk);
    if (!resetn) begin
      mq.delete();
      exp_q.delete();
    end else begin
      if (hs) begin
        exp_q.push_back((bresp != 2'b00) || (bid != 4'd1));
        void'(mq.pop_front());
      end
      if (pf) mq.push_back(push_addr[31:2]);
    end
    @(negedge clk);
    n_vec++;
    if (data_ok !== (exp_q.size() != 0)) begin
      n_bad++;
      $display("FAIL sb_data_ok got %b want %b t=%0t", data_ok, exp_q.size() != 0, $time);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_vec++;
      if (data_err !== e) begin
        n_bad++;
        $display("FAIL sb_data_err got %b want %b t=%0t", data_err, e, $time);
      end
    end
    n_vec++;
    if (count !== 3'(mq.size()) || bready !== (mq.size() != 0) || empty !== (mq.size() == 0)
        || push_ready !== (mq.size() != DEPTH)) begin
      n_bad++;
      $display("FAIL sb_state count=%0d bready=%b empty=%b push_ready=%b want count=%0d t=%0t",
               count, bready, empty, push_ready, mq.size(), $time);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    idle();
    rd_chk_addr = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (count !== 3'd0 || empty !== 1'b1 || push_ready !== 1'b1 || bready !== 1'b0
        || data_ok !== 1'b0 || data_err !== 1'b0 || raw_hazard !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state count=%0d empty=%b push_ready=%b bready=%b ok=%b err=%b hz=%b want 0 1 1 0 0 0 0",
               count, empty, push_ready, bready, data_ok, data_err, raw_hazard);
    end
    push_valid = 1'b1;
    #1;
    n_vec++;
    if (raw_hazard !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_push_hazard got %b want 1", raw_hazard);
    end
    push_valid = 1'b0;
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_single();
    push_valid = 1'b1;
    push_addr = 32'h1000_0004;
    tick();
    push_valid = 1'b0;
    n_vec++;
    if (bready !== 1'b1) begin
      n_bad++;
      $display("FAIL single_bready got %b want 1", bready);
    end
    tick();
    bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
    n_vec++;
    if (data_ok !== 1'b1 || data_err !== 1'b0 || empty !== 1'b1) begin
      n_bad++;
      $display("FAIL single_done ok=%b err=%b empty=%b want 1 0 1", data_ok, data_err, empty);
    end
    tick();
    n_vec++;
    if (data_ok !== 1'b0) begin
      n_bad++;
      $display("FAIL single_pulse_width got %b want 0", data_ok);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      push_valid = 1'b1;
      push_addr = 32'h4000_0000 + 32'(i * 16);
      tick();
    end
    n_vec++;
    if (count !== 3'd4 || push_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL fill_full count=%0d push_ready=%b want 4 0", count, push_ready);
    end
    push_addr = 32'h4000_0100;
    bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
    n_vec++;
    if (count !== 3'd3) begin
      n_bad++;
      $display("FAIL fill_reject count=%0d want 3", count);
    end
    tick();
    push_valid = 1'b0;
    n_vec++;
    if (count !== 3'd4) begin
      n_bad++;
      $display("FAIL fill_retry count=%0d want 4", count);
    end
    bvalid = 1'b1;
    repeat (4) tick();
    idle();
    tick();
  endtask

  task automatic test_hazard();
    push_valid = 1'b1;
    push_addr = 32'h2000_0008;
    rd_chk_addr = 32'h2000_000B;
    #1;
    n_vec++;
    if (raw_hazard !== 1'b1) begin
      n_bad++;
      $display("FAIL hz_incoming got %b want 1", raw_hazard);
    end
    tick();
    push_valid = 1'b0;
    #1;
    n_vec++;
    if (raw_hazard !== 1'b1) begin
      n_bad++;
      $display("FAIL hz_pending got %b want 1", raw_hazard);
    end
    rd_chk_addr = 32'h2000_000C;
    #1;
    n_vec++;
    if (raw_hazard !== 1'b0) begin
      n_bad++;
      $display("FAIL hz_next_word got %b want 0", raw_hazard);
    end
    rd_chk_addr = 32'h2000_000B;
    bvalid = 1'b1;
    #1;
    n_vec++;
    if (raw_hazard !== 1'b1) begin
      n_bad++;
      $display("FAIL hz_popping got %b want 1", raw_hazard);
    end
    tick();
    bvalid = 1'b0;
    #1;
    n_vec++;
    if (raw_hazard !== 1'b0) begin
      n_bad++;
      $display("FAIL hz_after_pop got %b want 0", raw_hazard);
    end
    tick();
  endtask

  task automatic test_errors();
    push_valid = 1'b1;
    push_addr = 32'h5000_0000;
    tick();
    push_addr = 32'h5000_0004;
    tick();
    push_valid = 1'b0;
    bvalid = 1'b1;
    bresp = 2'b10;
    tick();
    n_vec++;
    if (data_ok !== 1'b1 || data_err !== 1'b1 || count !== 3'd1) begin
      n_bad++;
      $display("FAIL err_slverr ok=%b err=%b count=%0d want 1 1 1", data_ok, data_err, count);
    end
    bresp = 2'b00;
    bid = 4'd2;
    tick();
    idle();
    n_vec++;
    if (data_ok !== 1'b1 || data_err !== 1'b1 || empty !== 1'b1) begin
      n_bad++;
      $display("FAIL err_bad_id ok=%b err=%b empty=%b want 1 1 1", data_ok, data_err, empty);
    end
    tick();
  endtask

  task automatic test_wrap();
    int ok_cnt;
    ok_cnt = 0;
    push_valid = 1'b1;
    push_addr = 32'h3000_0000;
    tick();
    for (int i = 1; i <= 10; i++) begin
      push_valid = 1'b1;
      push_addr = 32'h3000_0000 + 32'(i * 4);
      bvalid = 1'b1;
      rd_chk_addr = push_addr;
      tick();
      if (data_ok === 1'b1) ok_cnt++;
      n_vec++;
      if (count !== 3'd1) begin
        n_bad++;
        $display("FAIL wrap_count i=%0d count=%0d want 1", i, count);
      end
      push_valid = 1'b0;
      bvalid = 1'b0;
      #1;
      n_vec++;
      if (raw_hazard !== 1'b1) begin
        n_bad++;
        $display("FAIL wrap_hz_newest i=%0d got %b want 1", i, raw_hazard);
      end
      rd_chk_addr = 32'h3000_0000 + 32'((i - 1) * 4);
      #1;
      n_vec++;
      if (raw_hazard !== 1'b0) begin
        n_bad++;
        $display("FAIL wrap_hz_stale i=%0d got %b want 0", i, raw_hazard);
      end
    end
    n_vec++;
    if (ok_cnt != 10) begin
      n_bad++;
      $display("FAIL wrap_ok_pulses got %0d want 10", ok_cnt);
    end
    bvalid = 1'b1;
    tick();
    idle();
    tick();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      push_valid = 1'b1;
      push_addr = 32'h6000_0000 + 32'(i * 4);
      tick();
    end
    push_valid = 1'b0;
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    n_vec++;
    if (count !== 3'd0 || bready !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_state count=%0d bready=%b want 0 0", count, bready);
    end
    bvalid = 1'b1;
    repeat (2) begin
      tick();
      n_vec++;
      if (data_ok !== 1'b0) begin
        n_bad++;
        $display("FAIL rstmid_no_ok got %b want 0", data_ok);
      end
    end
    idle();
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_hazard();
    test_errors();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
